uart_fifo_bridge: RTL and testbench

//  Parametrised full-duplex UART with a buffered receive path and a selectable echo mode.

---
 rtl/uart_fifo_bridge.sv | 383 ++++++++++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_bridge.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_bridge.sv
// Full-duplex UART with an RX FIFO and a hardware echo path from the RX FIFO to TX.
// Define UART_PARITY_EN to add one even-parity bit per frame and the o_Parity_Err port.
module uart_fifo_bridge #(
  parameter int CLKS_PER_BIT = 457,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                             i_Clock,
  input  logic                             i_Reset,
  input  logic                             i_Rx_Serial,
  input  logic                             i_Echo_En,
  output logic [DATA_BITS-1:0]             o_Rx_Byte,
  output logic                             o_Rx_Valid,
  input  logic                             i_Rx_Ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_Rx_Count,
  output logic                             o_Rx_Overrun,
  output logic                             o_Frame_Err,
`ifdef UART_PARITY_EN
  output logic                             o_Parity_Err,
`endif
  input  logic [DATA_BITS-1:0]             i_Tx_Byte,
  input  logic                             i_Tx_Valid,
  output logic                             o_Tx_Ready,
  output logic                             o_Tx_Serial,
  output logic                             o_Tx_Active,
  output logic                             o_Tx_Done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]     CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]     CNT_HALF   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]     BIT_ZERO   = {BIT_W{1'b0}};
  localparam logic [BIT_W-1:0]     BIT_LAST   = BIT_W'(DATA_BITS - 1);
  localparam logic [DATA_BITS-1:0] DATA_ZERO  = {DATA_BITS{1'b0}};
  localparam logic [AW-1:0]        PTR_ZERO   = {AW{1'b0}};
  localparam logic [CW-1:0]        COUNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]        COUNT_FULL = CW'(FIFO_DEPTH);

`ifdef UART_PARITY_EN
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    even_parity = ^data;
  endfunction
`endif

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
`ifdef UART_PARITY_EN
    RX_PARITY    = 3'd3,
`endif
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    TX_PARITY = 3'd3,
`endif
    TX_STOP   = 3'd4
  } tx_state_t;

  // ---------------- RX engine ----------------
  logic                 rx_meta_r, rx_sync_r;
  rx_state_t            rx_state_r, rx_state_s;
  logic [CNT_W-1:0]     rx_cnt_r, rx_cnt_s;
  logic [BIT_W-1:0]     rx_bit_r, rx_bit_s;
  logic [DATA_BITS-1:0] rx_shift_r, rx_shift_s;
  logic                 push_s, frame_err_s, overrun_s;
  logic                 overrun_r, frame_err_r;
`ifdef UART_PARITY_EN
  logic                 rx_par_r, rx_par_s, parity_err_s, parity_err_r;
`endif

  // RX next-state: mid-bit sampling driven by a per-bit cycle counter
  always_comb begin
    rx_state_s  = rx_state_r;
    rx_cnt_s    = rx_cnt_r;
    rx_bit_s    = rx_bit_r;
    rx_shift_s  = rx_shift_r;
    push_s      = 1'b0;
    frame_err_s = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_s     = rx_par_r;
    parity_err_s = 1'b0;
`endif
    case (rx_state_r)
      RX_IDLE: begin
        rx_cnt_s = CNT_ZERO;
        rx_bit_s = BIT_ZERO;
        if (!rx_sync_r) rx_state_s = RX_START;
        else            rx_state_s = RX_IDLE;
      end
      RX_START: begin
        if (rx_cnt_r == CNT_HALF) begin
          rx_cnt_s = CNT_ZERO;
          // a line that is high again at mid-start was only a glitch
          if (rx_sync_r) rx_state_s = RX_IDLE;
          else           rx_state_s = RX_DATA;
        end else begin
          rx_cnt_s = rx_cnt_r + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_r == CNT_LAST) begin
          rx_cnt_s   = CNT_ZERO;
          rx_shift_s = {rx_sync_r, rx_shift_r[DATA_BITS-1:1]};
          if (rx_bit_r == BIT_LAST) begin
`ifdef UART_PARITY_EN
            rx_state_s = RX_PARITY;
`else
            rx_state_s = RX_STOP;
`endif
          end else begin
            rx_bit_s = rx_bit_r + 1'b1;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rx_cnt_r == CNT_LAST) begin
          rx_cnt_s   = CNT_ZERO;
          rx_par_s   = rx_sync_r;
          rx_state_s = RX_STOP;
        end else begin
          rx_cnt_s = rx_cnt_r + 1'b1;
        end
      end
`endif
      RX_STOP: begin
        if (rx_cnt_r == CNT_LAST) begin
          rx_cnt_s = CNT_ZERO;
          if (rx_sync_r) begin
            rx_state_s = RX_IDLE;
`ifdef UART_PARITY_EN
            if (rx_par_r != even_parity(rx_shift_r)) parity_err_s = 1'b1;
            else                                     push_s       = 1'b1;
`else
            push_s = 1'b1;
`endif
          end else begin
            frame_err_s = 1'b1;
            rx_state_s  = RX_WAIT_HIGH;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_sync_r) rx_state_s = RX_IDLE;
        else           rx_state_s = RX_WAIT_HIGH;
      end
      default: rx_state_s = RX_IDLE;
    endcase
  end

  // RX synchroniser, RX FSM registers and error pulses
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_meta_r   <= 1'b1;
      rx_sync_r   <= 1'b1;
      rx_state_r  <= RX_IDLE;
      rx_cnt_r    <= CNT_ZERO;
      rx_bit_r    <= BIT_ZERO;
      rx_shift_r  <= DATA_ZERO;
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_r     <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      rx_meta_r   <= i_Rx_Serial;
      rx_sync_r   <= rx_meta_r;
      rx_state_r  <= rx_state_s;
      rx_cnt_r    <= rx_cnt_s;
      rx_bit_r    <= rx_bit_s;
      rx_shift_r  <= rx_shift_s;
      overrun_r   <= overrun_s;
      frame_err_r <= frame_err_s;
`ifdef UART_PARITY_EN
      rx_par_r     <= rx_par_s;
      parity_err_r <= parity_err_s;
`endif
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]        count_r;
  logic                 empty_s, full_s, host_pop_s, echo_pop_s, pop_s, wr_en_s;

  assign empty_s    = (count_r == COUNT_ZERO);
  assign full_s     = (count_r == COUNT_FULL);
  assign host_pop_s = !i_Echo_En && i_Rx_Ready && !empty_s;
  assign pop_s      = host_pop_s || echo_pop_s;
  // a pop in the same cycle frees the slot, so full is only an overrun without one
  assign wr_en_s    = push_s && (!full_s || pop_s);
  assign overrun_s  = push_s && full_s && !pop_s;

  // FIFO storage, written only on accepted pushes
  always_ff @(posedge i_Clock) begin
    if (wr_en_s) mem_r[wr_ptr_r] <= rx_shift_r;
    else         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= COUNT_ZERO;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_s)   rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // ---------------- TX engine ----------------
  tx_state_t            tx_state_r, tx_state_s;
  logic [CNT_W-1:0]     tx_cnt_r, tx_cnt_s;
  logic [BIT_W-1:0]     tx_bit_r, tx_bit_s;
  logic [DATA_BITS-1:0] tx_shift_r, tx_shift_s;
  logic                 tx_serial_r, tx_serial_s;
  logic                 tx_active_r, tx_active_s;
  logic                 tx_done_r, tx_done_s;
`ifdef UART_PARITY_EN
  logic                 tx_par_r, tx_par_s;
`endif

  // TX next-state: the serial level for the next bit is registered on its first cycle
  always_comb begin
    tx_state_s  = tx_state_r;
    tx_cnt_s    = tx_cnt_r;
    tx_bit_s    = tx_bit_r;
    tx_shift_s  = tx_shift_r;
    tx_serial_s = tx_serial_r;
    tx_active_s = tx_active_r;
    tx_done_s   = 1'b0;
    echo_pop_s  = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_s    = tx_par_r;
`endif
    case (tx_state_r)
      TX_IDLE: begin
        tx_cnt_s    = CNT_ZERO;
        tx_bit_s    = BIT_ZERO;
        tx_serial_s = 1'b1;
        tx_active_s = 1'b0;
        if (i_Echo_En && !empty_s) begin
          echo_pop_s  = 1'b1;
          tx_shift_s  = mem_r[rd_ptr_r];
          tx_serial_s = 1'b0;
          tx_active_s = 1'b1;
          tx_state_s  = TX_START;
        end else if (!i_Echo_En && i_Tx_Valid) begin
          tx_shift_s  = i_Tx_Byte;
          tx_serial_s = 1'b0;
          tx_active_s = 1'b1;
          tx_state_s  = TX_START;
        end else begin
          tx_state_s = TX_IDLE;
        end
`ifdef UART_PARITY_EN
        tx_par_s = even_parity(tx_shift_s);
`endif
      end
      TX_START: begin
        if (tx_cnt_r == CNT_LAST) begin
          tx_cnt_s    = CNT_ZERO;
          tx_serial_s = tx_shift_r[0];
          tx_state_s  = TX_DATA;
        end else begin
          tx_cnt_s = tx_cnt_r + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_r == CNT_LAST) begin
          tx_cnt_s = CNT_ZERO;
          if (tx_bit_r == BIT_LAST) begin
`ifdef UART_PARITY_EN
            tx_serial_s = tx_par_r;
            tx_state_s  = TX_PARITY;
`else
            tx_serial_s = 1'b1;
            tx_state_s  = TX_STOP;
`endif
          end else begin
            tx_bit_s    = tx_bit_r + 1'b1;
            tx_serial_s = tx_shift_r[1];
            tx_shift_s  = {1'b0, tx_shift_r[DATA_BITS-1:1]};
          end
        end else begin
          tx_cnt_s = tx_cnt_r + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (tx_cnt_r == CNT_LAST) begin
          tx_cnt_s    = CNT_ZERO;
          tx_serial_s = 1'b1;
          tx_state_s  = TX_STOP;
        end else begin
          tx_cnt_s = tx_cnt_r + 1'b1;
        end
      end
`endif
      TX_STOP: begin
        if (tx_cnt_r == CNT_LAST) begin
          tx_cnt_s    = CNT_ZERO;
          tx_serial_s = 1'b1;
          tx_active_s = 1'b0;
          tx_done_s   = 1'b1;
          tx_state_s  = TX_IDLE;
        end else begin
          tx_cnt_s = tx_cnt_r + 1'b1;
        end
      end
      default: begin
        tx_serial_s = 1'b1;
        tx_active_s = 1'b0;
        tx_state_s  = TX_IDLE;
      end
    endcase
  end

  // TX FSM and output registers
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      tx_state_r  <= TX_IDLE;
      tx_cnt_r    <= CNT_ZERO;
      tx_bit_r    <= BIT_ZERO;
      tx_shift_r  <= DATA_ZERO;
      tx_serial_r <= 1'b1;
      tx_active_r <= 1'b0;
      tx_done_r   <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_r    <= 1'b0;
`endif
    end else begin
      tx_state_r  <= tx_state_s;
      tx_cnt_r    <= tx_cnt_s;
      tx_bit_r    <= tx_bit_s;
      tx_shift_r  <= tx_shift_s;
      tx_serial_r <= tx_serial_s;
      tx_active_r <= tx_active_s;
      tx_done_r   <= tx_done_s;
`ifdef UART_PARITY_EN
      tx_par_r    <= tx_par_s;
`endif
    end
  end

  assign o_Rx_Valid   = !empty_s && !i_Echo_En;
  assign o_Rx_Byte    = o_Rx_Valid ? mem_r[rd_ptr_r] : DATA_ZERO;
  assign o_Rx_Count   = count_r;
  assign o_Rx_Overrun = overrun_r;
  assign o_Frame_Err  = frame_err_r;
`ifdef UART_PARITY_EN
  assign o_Parity_Err = parity_err_r;
`endif
  assign o_Tx_Ready   = (tx_state_r == TX_IDLE) && !i_Echo_En && !i_Reset;
  assign o_Tx_Serial  = tx_serial_r;
  assign o_Tx_Active  = tx_active_r;
  assign o_Tx_Done    = tx_done_r;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed plus randomized bench for uart_fifo_bridge with a queue-based reference model.
// Builds with or without UART_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_fifo_bridge;
  localparam int C     = 8;
  localparam int DB    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NBITS = DB + 2 + PB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_serial = 1'b1;
  logic          echo_en = 1'b0;
  logic          rx_ready = 1'b0;
  logic [DB-1:0] tx_byte = 8'h00;
  logic          tx_valid = 1'b0;
  logic [DB-1:0] rx_byte;
  logic [CW-1:0] rx_count;
  logic          rx_valid, rx_overrun, frame_err, tx_ready, tx_serial, tx_active, tx_done;
`ifdef UART_PARITY_EN
  logic          parity_err;
`endif

  uart_fifo_bridge #(.CLKS_PER_BIT(C), .DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_serial), .i_Echo_En(echo_en),
    .o_Rx_Byte(rx_byte), .o_Rx_Valid(rx_valid), .i_Rx_Ready(rx_ready),
    .o_Rx_Count(rx_count), .o_Rx_Overrun(rx_overrun), .o_Frame_Err(frame_err),
`ifdef UART_PARITY_EN
    .o_Parity_Err(parity_err),
`endif
    .i_Tx_Byte(tx_byte), .i_Tx_Valid(tx_valid), .o_Tx_Ready(tx_ready),
    .o_Tx_Serial(tx_serial), .o_Tx_Active(tx_active), .o_Tx_Done(tx_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0, done_cnt = 0, ovr_cnt = 0, ferr_cnt = 0, perr_cnt = 0, echo_valid_cnt = 0;
  bit echo_phase = 1'b0;
  logic [DB-1:0] model_q[$];
  int exp_ovr = 0;

  // pulse monitors
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_done === 1'b1)    done_cnt <= done_cnt + 1;
    if (rx_overrun === 1'b1) ovr_cnt  <= ovr_cnt + 1;
    if (frame_err === 1'b1)  ferr_cnt <= ferr_cnt + 1;
    if (echo_phase && rx_valid !== 1'b0) echo_valid_cnt <= echo_valid_cnt + 1;
`ifdef UART_PARITY_EN
    if (parity_err === 1'b1) perr_cnt <= perr_cnt + 1;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rx_bit(input logic b);
    rx_serial = b;
    tick(C);
  endtask

  // drives one frame onto the RX line, correct parity when enabled
  task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit);
    rx_bit(1'b0);
    for (int i = 0; i < DB; i++) rx_bit(d[i]);
`ifdef UART_PARITY_EN
    rx_bit(^d);
`endif
    rx_bit(stop_bit);
    rx_serial = 1'b1;
  endtask

`ifdef UART_PARITY_EN
  task automatic send_frame_par(input logic [DB-1:0] d, input logic par);
    rx_bit(1'b0);
    for (int i = 0; i < DB; i++) rx_bit(d[i]);
    rx_bit(par);
    rx_bit(1'b1);
  endtask
`endif

  function automatic void model_push(input logic [DB-1:0] d);
    if (model_q.size() < DEPTH) model_q.push_back(d);
    else exp_ovr++;
  endfunction

  task automatic pop_check(input string tag);
    logic [DB-1:0] exp;
    exp = model_q.pop_front();
    check({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
    check({tag, "_byte"}, {24'd0, rx_byte}, {24'd0, exp});
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  function automatic logic tx_exp_bit(input logic [DB-1:0] d, input int i);
    if (i == 0) return 1'b0;
    else if (i <= DB) return d[i-1];
    else if (i == NBITS - 1) return 1'b1;
    else return ^d;
  endfunction

  // host-mode transmit with per-bit and done-latency checks
  task automatic host_send(input logic [DB-1:0] d);
    int k, t0;
    k = 0;
    while (tx_ready !== 1'b1 && k < 4 * NBITS * C) begin tick(1); k++; end
    check("tx_ready_idle", {31'd0, tx_ready}, 32'd1);
    tx_byte = d; tx_valid = 1'b1; t0 = cyc;
    tick(1);
    tx_valid = 1'b0;
    check("tx_active_start", {31'd0, tx_active}, 32'd1);
    check("tx_ready_busy", {31'd0, tx_ready}, 32'd0);
    tick(C / 2);
    for (int i = 0; i < NBITS; i++) begin
      check($sformatf("tx_bit%0d", i), {31'd0, tx_serial}, {31'd0, tx_exp_bit(d, i)});
      if (i < NBITS - 1) tick(C);
    end
    k = 0;
    while (tx_done !== 1'b1 && k < 2 * C) begin tick(1); k++; end
    check("tx_done_latency", cyc - t0, NBITS * C + 1);
    check("tx_active_at_done", {31'd0, tx_active}, 32'd0);
    tick(1);
    check("tx_done_pulse", {31'd0, tx_done}, 32'd0);
  endtask

  // waits for a start bit on o_Tx_Serial and samples the frame mid-bit
  task automatic capture_frame(output logic [DB-1:0] d, output logic ok);
    int k;
    k = 0; d = 8'h00; ok = 1'b0;
    while (tx_serial !== 1'b0 && k < 3 * NBITS * C) begin tick(1); k++; end
    if (tx_serial === 1'b0) begin
      tick(C / 2);
      for (int i = 0; i < DB; i++) begin tick(C); d[i] = tx_serial; end
`ifdef UART_PARITY_EN
      tick(C);
      check("echo_parity", {31'd0, tx_serial}, {31'd0, ^d});
`endif
      tick(C);
      ok = tx_serial;
    end
  endtask

  initial begin
    logic [DB-1:0] d, exp_q[$];
    int ferr0, perr0, done0;

    // reset state
    tick(3);
    check("rst_tx_serial", {31'd0, tx_serial}, 32'd1);
    check("rst_tx_active", {31'd0, tx_active}, 32'd0);
    check("rst_tx_done", {31'd0, tx_done}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_rx_count", {{(32-CW){1'b0}}, rx_count}, 32'd0);
    check("rst_rx_byte", {24'd0, rx_byte}, 32'd0);
    check("rst_errs", {30'd0, rx_overrun, frame_err}, 32'd0);
    rst = 1'b0;
    tick(2);
    check("post_rst_ready", {31'd0, tx_ready}, 32'd1);

    // host TX: directed 0xA5 then random bytes
    host_send(8'hA5);
    for (int n = 0; n < 3; n++) host_send(DB'($urandom));

    // 17 frames into a 16-deep FIFO with no pops
    for (int i = 0; i <= 16; i++) begin
      send_frame(DB'(i), 1'b1);
      model_push(DB'(i));
    end
    tick(2);
    check("fill_count", {{(32-CW){1'b0}}, rx_count}, model_q.size());
    check("fill_overrun", ovr_cnt, exp_ovr);
    while (model_q.size() > 0) pop_check("fill_pop");
    check("drain_count", {{(32-CW){1'b0}}, rx_count}, 32'd0);
    check("drain_valid", {31'd0, rx_valid}, 32'd0);

    // short glitch must not start a frame or raise an error
    ferr0 = ferr_cnt;
    rx_serial = 1'b0; tick(2); rx_serial = 1'b1; tick(2 * C);
    check("glitch_ferr", ferr_cnt, ferr0);
    check("glitch_count", {{(32-CW){1'b0}}, rx_count}, 32'd0);

    // framing error then a good frame
    send_frame(8'h3C, 1'b0);
    tick(C);
    check("ferr_pulse", ferr_cnt, ferr0 + 1);
    check("ferr_count", {{(32-CW){1'b0}}, rx_count}, 32'd0);
    send_frame(8'h3D, 1'b1);
    model_push(8'h3D);
    tick(2);
    check("after_ferr_count", {{(32-CW){1'b0}}, rx_count}, 32'd1);
    pop_check("after_ferr_pop");

    // random frames with random interleaved pops
    for (int n = 0; n < 8; n++) begin
      d = DB'($urandom);
      send_frame(d, 1'b1);
      model_push(d);
      if ($urandom_range(0, 1) == 1) pop_check("rand_pop");
    end
    check("rand_count", {{(32-CW){1'b0}}, rx_count}, model_q.size());
    while (model_q.size() > 0) pop_check("rand_drain");

`ifdef UART_PARITY_EN
    perr0 = perr_cnt;
    send_frame_par(8'h07, 1'b0);
    tick(2);
    check("par_err_pulse", perr_cnt, perr0 + 1);
    check("par_err_count", {{(32-CW){1'b0}}, rx_count}, 32'd0);
    send_frame_par(8'h07, 1'b1);
    model_push(8'h07);
    tick(2);
    check("par_ok_count", {{(32-CW){1'b0}}, rx_count}, 32'd1);
    pop_check("par_ok_pop");
`else
    perr0 = perr_cnt;
    check("no_parity_pulses", perr_cnt, perr0);
`endif

    // echo mode: RX bytes reappear on TX in order, host side sees nothing
    echo_en = 1'b1; rx_ready = 1'b1; echo_phase = 1'b1;
    tick(2);
    check("echo_tx_ready", {31'd0, tx_ready}, 32'd0);
    exp_q = '{8'h55, 8'hAA, 8'h0F};
    fork
      begin
        send_frame(8'h55, 1'b1); send_frame(8'hAA, 1'b1); send_frame(8'h0F, 1'b1);
      end
      begin
        logic [DB-1:0] got;
        logic ok;
        for (int n = 0; n < 3; n++) begin
          capture_frame(got, ok);
          check($sformatf("echo_stop%0d", n), {31'd0, ok}, 32'd1);
          check($sformatf("echo_byte%0d", n), {24'd0, got}, {24'd0, exp_q[n]});
        end
      end
    join
    tick(2 * C);
    echo_phase = 1'b0;
    check("echo_rx_valid", echo_valid_cnt, 32'd0);
    check("echo_count", {{(32-CW){1'b0}}, rx_count}, 32'd0);
    echo_en = 1'b0; rx_ready = 1'b0;
    tick(2);

    // reset in the middle of a TX frame
    send_frame(8'h42, 1'b1);
    tick(2);
    check("pre_rst_count", {{(32-CW){1'b0}}, rx_count}, 32'd1);
    tx_byte = 8'h5A; tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tick(3 * C + 2);
    check("mid_frame_active", {31'd0, tx_active}, 32'd1);
    done0 = done_cnt;
    rst = 1'b1;
    #2;
    check("mid_rst_serial", {31'd0, tx_serial}, 32'd1);
    check("mid_rst_active", {31'd0, tx_active}, 32'd0);
    check("mid_rst_count", {{(32-CW){1'b0}}, rx_count}, 32'd0);
    tick(3);
    rst = 1'b0;
    tick(NBITS * C + 4);
    check("mid_rst_no_done", done_cnt, done0);
    check("mid_rst_idle_serial", {31'd0, tx_serial}, 32'd1);
    check("mid_rst_rx_valid", {31'd0, rx_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
